// File: rtl/sfu_buffer_reader_if.sv
// Output stream of the SFU buffer reader: valid/ready handshake plus data word.
// The reader drives the master side; the SFU output port consumes the slave side.
interface sfu_buffer_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/sfu_buffer_reader.sv
// Read-side controller for the SFU result buffer: mirrors buffer occupancy from the push
// strobe, issues pops on a credit basis and streams words out through a 2-entry skid queue.
module sfu_buffer_reader #(
    parameter  int FIFO_DEPTH = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    sfu_buffer_reader_if.master   m_if,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  buf_full,
    output logic                  buf_empty,
    output logic                  overflow
);

    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_next;
    logic                  overflow_q;
    logic                  inflight_q;
    logic [1:0]            skid_cnt_q;
    logic                  skid_head_q;
    logic                  skid_tail_q;
    logic [DATA_WIDTH-1:0] skid_mem_q [2];

    logic                  push_acc;
    logic                  pop_out;
    logic                  m_valid_int;
    logic [2:0]            skid_level;

    assign buf_full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign buf_empty   = (occ_q == '0);
    assign push_acc    = fifo_wr_en & ~buf_full;
    assign m_valid_int = (skid_cnt_q != 2'd0);
    assign pop_out     = m_valid_int & m_if.m_ready;

    // Words the skid queue will hold next cycle; a pop is only issued if it leaves room
    // for the word it returns, which is what keeps the queue from ever overflowing.
    assign skid_level  = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_out};
    assign fifo_rd_en  = ~buf_empty & (skid_level < 3'd2);

    always_comb begin
        occ_next = occ_q;
        case ({push_acc, fifo_rd_en})
            2'b10:   occ_next = occ_q + OCC_W'(1);
            2'b01:   occ_next = occ_q - OCC_W'(1);
            default: occ_next = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= '0;
            overflow_q    <= 1'b0;
            inflight_q    <= 1'b0;
            skid_cnt_q    <= 2'd0;
            skid_head_q   <= 1'b0;
            skid_tail_q   <= 1'b0;
            skid_mem_q[0] <= '0;
            skid_mem_q[1] <= '0;
        end else begin
            occ_q      <= occ_next;
            overflow_q <= overflow_q | (fifo_wr_en & buf_full);
            inflight_q <= fifo_rd_en;
            skid_cnt_q <= skid_level[1:0];
            // The buffer's read data is valid exactly one cycle after the pop strobe.
            if (inflight_q) begin
                skid_mem_q[skid_tail_q] <= fifo_data_out;
                skid_tail_q             <= ~skid_tail_q;
            end
            if (pop_out) begin
                skid_head_q <= ~skid_head_q;
            end
        end
    end

    assign m_if.m_valid = m_valid_int;
    assign m_if.m_data  = skid_mem_q[skid_head_q];
    assign occupancy    = occ_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_sfu_buffer_reader.sv
// Bench for sfu_buffer_reader: behavioural result buffer, ordered scoreboard and directed timing checks.
module tb_sfu_buffer_reader;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data_out = '0;
    logic [4:0]    occupancy;
    logic          buf_full;
    logic          buf_empty;
    logic          overflow;

    sfu_buffer_reader_if #(.DATA_WIDTH(DW)) s_if ();

    sfu_buffer_reader #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_wr_en    (wr_en),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .m_if          (s_if.master),
        .occupancy     (occupancy),
        .buf_full      (buf_full),
        .buf_empty     (buf_empty),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural result buffer (registered read port) plus the reference word order.
    logic [DW-1:0] ram [DEPTH];
    int            wp = 0;
    int            rp = 0;
    int            ref_cnt = 0;
    logic          ref_ovf = 1'b0;
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            wp = 0; rp = 0; ref_cnt = 0; ref_ovf = 1'b0;
            exp_q.delete();
        end else begin
            int cnt_before;
            cnt_before = ref_cnt;
            fifo_data_out <= ram[rp];
            if (wr_en) begin
                if (cnt_before < DEPTH) begin
                    ram[wp] = wr_data;
                    wp = (wp + 1) % DEPTH;
                    ref_cnt++;
                    exp_q.push_back(wr_data);
                end else begin
                    ref_ovf = 1'b1;
                end
            end
            if (fifo_rd_en && cnt_before > 0) begin
                rp = (rp + 1) % DEPTH;
                ref_cnt--;
            end
        end
    end

    // Monitor: buffer bookkeeping every cycle, stream protocol and word order on each transfer.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("occupancy", occupancy, ref_cnt);
            check("buf_full", buf_full, ref_cnt == DEPTH);
            check("buf_empty", buf_empty, ref_cnt == 0);
            check("overflow", overflow, ref_ovf);
            if (ref_cnt == 0) check("rd_en_while_empty", fifo_rd_en, 1'b0);
            if (prev_stall) begin
                check("hold_valid", s_if.m_valid, 1'b1);
                check("hold_data", s_if.m_data, prev_data);
            end
            if (s_if.m_valid && s_if.m_ready) begin
                check("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("data_order", s_if.m_data, exp_q.pop_front());
            end
            prev_stall = s_if.m_valid & ~s_if.m_ready;
            prev_data  = s_if.m_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        s_if.m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) cyc();
        @(negedge clk);
        check({name, "_occ"}, occupancy, 0);
        check({name, "_empty"}, buf_empty, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int burst;
        int gap;
        s_if.m_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_m_valid", s_if.m_valid, 1'b0);
        check("rst_m_data", s_if.m_data, 0);
        check("rst_occ", occupancy, 0);
        check("rst_full", buf_full, 1'b0);
        check("rst_empty", buf_empty, 1'b1);
        check("rst_overflow", overflow, 1'b0);

        // Single word: rd_en at t+1, valid for exactly one cycle at t+3.
        cyc(); wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        @(negedge clk);
        check("single_t0_valid", s_if.m_valid, 1'b0);
        cyc(); wr_en = 1'b0;
        @(negedge clk);
        check("single_t1_occ", occupancy, 1);
        check("single_t1_rd_en", fifo_rd_en, 1'b1);
        cyc(); @(negedge clk);
        check("single_t2_occ", occupancy, 0);
        check("single_t2_valid", s_if.m_valid, 1'b0);
        cyc(); @(negedge clk);
        check("single_t3_valid", s_if.m_valid, 1'b1);
        check("single_t3_data", s_if.m_data, 32'hA5A5_0001);
        cyc(); @(negedge clk);
        check("single_t4_valid", s_if.m_valid, 1'b0);

        // Streaming: 16 back-to-back words come out gap-free from t+3.
        for (int i = 0; i < 19; i++) begin
            cyc();
            wr_en   = (i < 16);
            wr_data = i;
            @(negedge clk);
            if (i >= 3) check("stream_no_gap", s_if.m_valid, 1'b1);
        end
        cyc(); @(negedge clk);
        check("stream_end_valid", s_if.m_valid, 1'b0);
        check("stream_overflow", overflow, 1'b0);

        // Backpressure: fill 16 words with the consumer stalled; only 2 pops happen.
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(); wr_en = 1'b1; wr_data = 32'hB000_0000 + i;
        end
        cyc(); wr_en = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        check("bp_occ", occupancy, 14);
        check("bp_rd_en", fifo_rd_en, 1'b0);
        check("bp_valid", s_if.m_valid, 1'b1);
        check("bp_data", s_if.m_data, 32'hB000_0000);

        // Top up to full, then push into a full buffer.
        cyc(); wr_en = 1'b1; wr_data = 32'hB000_0010;
        cyc(); wr_data = 32'hB000_0011;
        cyc(); wr_en = 1'b0;
        @(negedge clk);
        check("full_occ", occupancy, 16);
        check("full_flag", buf_full, 1'b1);
        check("full_no_ovf", overflow, 1'b0);
        cyc(); wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
        cyc(); wr_en = 1'b0;
        @(negedge clk);
        check("ovf_set", overflow, 1'b1);
        check("ovf_occ", occupancy, 16);

        // Push and pop together at full: credit release makes rd_en rise in the same cycle.
        cyc(); wr_en = 1'b1; wr_data = 32'hDEAD_0002; s_if.m_ready = 1'b1;
        @(negedge clk);
        check("release_rd_en", fifo_rd_en, 1'b1);
        cyc(); wr_en = 1'b0; s_if.m_ready = 1'b0;
        @(negedge clk);
        check("pushpop_occ", occupancy, 15);
        check("pushpop_ovf", overflow, 1'b1);

        // Drain with m_ready toggling every second cycle.
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            cyc();
            if (i % 2 == 0) s_if.m_ready = ~s_if.m_ready;
        end
        drain("toggle_drain");

        // Wrap-around: 40 words in random bursts with random backpressure.
        pushed = 0;
        while (pushed < 40) begin
            burst = $urandom_range(1, 6);
            for (int b = 0; b < burst && pushed < 40; b++) begin
                cyc();
                s_if.m_ready = 1'($urandom_range(0, 1));
                if (ref_cnt < DEPTH) begin
                    wr_en = 1'b1; wr_data = 100 + pushed; pushed++;
                end else begin
                    wr_en = 1'b0;
                end
            end
            cyc(); wr_en = 1'b0;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cyc(); s_if.m_ready = 1'($urandom_range(0, 1));
            end
        end
        cyc(); wr_en = 1'b0;
        drain("wrap_drain");

        // Mid-stream reset with skid queue full and 5 words still buffered.
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(); wr_en = 1'b1; wr_data = 32'hC000_0000 + i;
        end
        cyc(); wr_en = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("pre_rst_occ", occupancy, 5);
        check("pre_rst_valid", s_if.m_valid, 1'b1);
        check("pre_rst_rd_en", fifo_rd_en, 1'b0);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", s_if.m_valid, 1'b0);
        check("post_rst_occ", occupancy, 0);
        check("post_rst_ovf", overflow, 1'b0);
        check("post_rst_rd_en", fifo_rd_en, 1'b0);
        cyc(); wr_en = 1'b1; wr_data = 32'h0000_1234; s_if.m_ready = 1'b1;
        cyc(); wr_en = 1'b0;
        cyc(); @(negedge clk);
        check("fresh_t2_valid", s_if.m_valid, 1'b0);
        cyc(); @(negedge clk);
        check("fresh_t3_valid", s_if.m_valid, 1'b1);
        check("fresh_t3_data", s_if.m_data, 32'h0000_1234);
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
